// File: rtl/ram_access_ctrl.sv
// Single-word request sequencer for the combinational RAMblock data memory.
// The address and data go out in SETUP, the strobe lasts waitcycles+1 clocks, then HOLD, then an ack pulse.
module ram_access_ctrl #(
    parameter int unsigned adlines    = 8,
    parameter int unsigned datalines  = 16,
    parameter int unsigned ramsize    = 256,
    parameter int unsigned waitcycles = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [adlines-1:0]   cpu_addr,
    input  logic [datalines-1:0] cpu_wdata,
    output logic [datalines-1:0] cpu_rdata,
    output logic                 ack,
    output logic                 err,
    output logic                 busy,
    output logic [adlines-1:0]   mem_address,
    output logic [datalines-1:0] mem_datain,
    input  logic [datalines-1:0] mem_dataout,
    output logic                 mem_read,
    output logic                 mem_write
);

    localparam int unsigned CntW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE,
        S_ERR
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [adlines-1:0]     addr_q, addr_d;
    logic [datalines-1:0]   wdata_q, wdata_d;
    logic [datalines-1:0]   rdata_q, rdata_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;
    logic                   out_of_range_c;

    // The address is zero-extended before the range compare, so a full address space never reports an error.
    assign out_of_range_c = (32'(cpu_addr) >= 32'(ramsize));

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Next state. The output flops are decoded from the next state so that they line up with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d = we;
                    if (out_of_range_c) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_SETUP;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end
            end
            S_SETUP: begin
                cnt_d   = CntW'(waitcycles);
                state_d = S_STROBE;
            end
            S_STROBE: begin
                // RAM output is valid while the read strobe is high, so it is captured on the exit edge.
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    if (!we_q) begin
                        rdata_d = mem_dataout;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            S_HOLD:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        ack_d  = (state_d == S_DONE) || (state_d == S_ERR);
        err_d  = (state_d == S_ERR);
        rd_d   = (state_d == S_STROBE) && !we_q;
        wr_d   = (state_d == S_STROBE) && we_q;
    end

    assign cpu_rdata   = rdata_q;
    assign ack         = ack_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign mem_address = addr_q;
    assign mem_datain  = wdata_q;
    assign mem_read    = rd_q;
    assign mem_write   = wr_q;

endmodule
